// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchroniser/debouncer with press/release pulses and tick-aligned move command
module btn_conditioner #(
  parameter int NUM_BTN    = 5,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               tick_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               move_valid,
  output logic [3:0]         move_dir
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_BTN-1:0] s1_q, s2_q;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic               move_valid_q, move_valid_d;
  logic [3:0]         move_dir_q, move_dir_d;
  logic [3:0]         dirs;
  logic               one_dir;

  // Any sample matching the accepted level restarts the count, so only an
  // uninterrupted run of DEB_CYCLES differing samples flips the level.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          stable_d[i]  = s2_q[i];
          press_d[i]   = s2_q[i];
          release_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Moves use the pre-edge level; zero or several directions held is no move.
  assign dirs    = stable_q[4:1];
  assign one_dir = (dirs != 4'd0) && ((dirs & (dirs - 4'd1)) == 4'd0);

  always_comb begin
    move_valid_d = 1'b0;
    move_dir_d   = 4'd0;
    if (tick_in && one_dir) begin
      move_valid_d = 1'b1;
      move_dir_d   = dirs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      press_q      <= '0;
      release_q    <= '0;
      move_valid_q <= 1'b0;
      move_dir_q   <= 4'd0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q         <= btn_raw;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      press_q      <= press_d;
      release_q    <= release_d;
      move_valid_q <= move_valid_d;
      move_dir_q   <= move_dir_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign move_valid  = move_valid_q;
  assign move_dir    = move_dir_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic       tick_in;
  logic [4:0] btn_level, btn_press, btn_release;
  logic       move_valid;
  logic [3:0] move_dir;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] raw;
    logic       tick;
    logic       exp_valid;
    logic [3:0] exp_dir;
  } vec_t;

  typedef struct {
    logic       v;
    logic [3:0] d;
  } mv_t;

  vec_t vecs[10];
  mv_t  exp_q[$];

  btn_conditioner #(.NUM_BTN(5), .DEB_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .tick_in    (tick_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .move_valid (move_valid),
    .move_dir   (move_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive tick for one edge, queue the expected move, then compare after the edge.
  task automatic tick_check(input string name, input logic t, input logic ev, input logic [3:0] ed);
    mv_t e, got;
    tick_in = t;
    e.v = ev;
    e.d = ed;
    exp_q.push_back(e);
    step();
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = exp_q.pop_front();
      chk({name, "_valid"}, {31'd0, move_valid}, {31'd0, got.v});
      chk({name, "_dir"}, {28'd0, move_dir}, {28'd0, got.d});
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{raw: 5'b00010, tick: 1'b1, exp_valid: 1'b1, exp_dir: 4'b0001};
    vecs[1] = '{raw: 5'b00110, tick: 1'b1, exp_valid: 1'b0, exp_dir: 4'b0000};
    vecs[2] = '{raw: 5'b00001, tick: 1'b1, exp_valid: 1'b0, exp_dir: 4'b0000};
    vecs[3] = '{raw: 5'b00010, tick: 1'b0, exp_valid: 1'b0, exp_dir: 4'b0000};
    vecs[4] = '{raw: 5'b10000, tick: 1'b1, exp_valid: 1'b1, exp_dir: 4'b1000};
    vecs[5] = '{raw: 5'b01000, tick: 1'b1, exp_valid: 1'b1, exp_dir: 4'b0100};
    vecs[6] = '{raw: 5'b00101, tick: 1'b1, exp_valid: 1'b1, exp_dir: 4'b0010};
    vecs[7] = '{raw: 5'b11110, tick: 1'b1, exp_valid: 1'b0, exp_dir: 4'b0000};
    vecs[8] = '{raw: 5'b01000, tick: 1'b0, exp_valid: 1'b0, exp_dir: 4'b0000};
    vecs[9] = '{raw: 5'b00000, tick: 1'b1, exp_valid: 1'b0, exp_dir: 4'b0000};

    // Reset with all buttons and tick asserted
    rst = 1'b0;
    btn_raw = 5'b11111;
    tick_in = 1'b1;
    repeat (4) step();
    chk("rst_level", {27'd0, btn_level}, 32'd0);
    chk("rst_press", {27'd0, btn_press}, 32'd0);
    chk("rst_release", {27'd0, btn_release}, 32'd0);
    chk("rst_mvalid", {31'd0, move_valid}, 32'd0);
    chk("rst_mdir", {28'd0, move_dir}, 32'd0);

    rst = 1'b1;
    repeat (5) step();
    chk("rst_rel_early", {27'd0, btn_level}, 32'd0);
    step();
    chk("rst_rel_level", {27'd0, btn_level}, 32'h1f);
    chk("rst_rel_press", {27'd0, btn_press}, 32'h1f);
    chk("rst_rel_mvalid", {31'd0, move_valid}, 32'd0);
    tick_in = 1'b0;
    step();
    chk("rst_rel_press_off", {27'd0, btn_press}, 32'd0);

    btn_raw = 5'b00000;
    repeat (6) step();
    chk("all_release", {27'd0, btn_release}, 32'h1f);
    chk("all_release_level", {27'd0, btn_level}, 32'd0);
    repeat (2) step();

    // Clean press on button 1
    btn_raw[1] = 1'b1;
    repeat (5) step();
    chk("press1_early", {31'd0, btn_level[1]}, 32'd0);
    step();
    chk("press1_level", {31'd0, btn_level[1]}, 32'd1);
    chk("press1_pulse", {31'd0, btn_press[1]}, 32'd1);
    step();
    chk("press1_pulse_off", {31'd0, btn_press[1]}, 32'd0);
    chk("press1_hold", {31'd0, btn_level[1]}, 32'd1);
    btn_raw[1] = 1'b0;
    repeat (8) step();

    // Bounce on button 2: 3-cycle pulses never reach the level
    cnt = 0;
    for (int p = 0; p < 4; p++) begin
      btn_raw[2] = (p % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step();
        chk("bounce_level", {31'd0, btn_level[2]}, 32'd0);
        if (btn_press[2]) cnt++;
      end
    end
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bounce_settle", {31'd0, btn_level[2]}, 32'd0);
      if (btn_press[2]) cnt++;
    end
    step();
    chk("bounce_rise", {31'd0, btn_level[2]}, 32'd1);
    if (btn_press[2]) cnt++;
    repeat (3) begin
      step();
      if (btn_press[2]) cnt++;
    end
    chk("bounce_press_count", cnt, 32'd1);

    // Release on button 3
    btn_raw[3] = 1'b1;
    repeat (7) step();
    chk("rel3_pressed", {31'd0, btn_level[3]}, 32'd1);
    btn_raw[3] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (btn_release[3]) cnt++;
    end
    chk("rel3_early", {31'd0, btn_level[3]}, 32'd1);
    step();
    chk("rel3_pulse", {31'd0, btn_release[3]}, 32'd1);
    chk("rel3_level", {31'd0, btn_level[3]}, 32'd0);
    if (btn_release[3]) cnt++;
    repeat (3) begin
      step();
      if (btn_release[3]) cnt++;
    end
    chk("rel3_count", cnt, 32'd1);

    // Move legality table
    for (int v = 0; v < 10; v++) begin
      btn_raw = vecs[v].raw;
      tick_in = 1'b0;
      repeat (7) step();
      chk("tbl_level", {27'd0, btn_level}, {27'd0, vecs[v].raw});
      tick_check("tbl_move", vecs[v].tick, vecs[v].exp_valid, vecs[v].exp_dir);
      tick_in = 1'b0;
      step();
      chk("tbl_move_off", {31'd0, move_valid}, 32'd0);
    end

    // Tick on the same edge as a level flip samples the old level
    btn_raw = 5'b00010;
    repeat (5) step();
    chk("coinc_pre", {27'd0, btn_level}, 32'd0);
    tick_check("coinc_old", 1'b1, 1'b0, 4'b0000);
    chk("coinc_level", {27'd0, btn_level}, 32'h02);
    tick_in = 1'b0;
    step();
    tick_check("coinc_next", 1'b1, 1'b1, 4'b0001);
    tick_in = 1'b0;

    // Consecutive ticks each yield a move
    btn_raw = 5'b00100;
    repeat (7) step();
    for (int k = 0; k < 3; k++) tick_check("consec", 1'b1, 1'b1, 4'b0010);
    tick_in = 1'b0;
    step();
    chk("consec_off", {31'd0, move_valid}, 32'd0);

    // Reset mid-debounce on button 4 restarts the full latency
    btn_raw = 5'b00000;
    repeat (8) step();
    btn_raw[4] = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    #1;
    chk("mid_rst_level", {27'd0, btn_level}, 32'd0);
    step();
    rst = 1'b1;
    repeat (5) step();
    chk("mid_rst_no_early", {31'd0, btn_level[4]}, 32'd0);
    step();
    chk("mid_rst_level4", {31'd0, btn_level[4]}, 32'd1);
    chk("mid_rst_press4", {31'd0, btn_press[4]}, 32'd1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
